// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: MM:SS BCD countdown with load/start/pause/clear/add-30 commands.
module bcd_countdown_timer #(
  parameter int CLK_DIV      = 1,
  parameter int MAX_MIN_TENS = 9
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Load,
  input  logic [3:0] load_min_tens,
  input  logic [3:0] load_min_units,
  input  logic [2:0] load_sec_tens,
  input  logic [3:0] load_sec_units,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Clear,
  input  logic       Add30,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_units,
  output logic [1:0] state,
  output logic       timer_done,
  output logic       done_pulse
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
  localparam logic [3:0] MT = 4'(MAX_MIN_TENS);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3;
  logic [1:0] state_next;
  logic [PW-1:0] presc, presc_next;
  logic [3:0] mt_n, mu_n, su_n, a_mt, a_mu, d_mt, d_mu, d_su;
  logic [2:0] st_n, a_st, d_st;
  logic do_ld, do_add, do_st, do_ps, tick, zero, last;
  logic st_c, mu_c, sat, b0, b1, b2;
  // Only the highest-priority active command acts; an ignored command still blocks lower ones.
  always_comb begin
    zero   = {min_tens, min_units, sec_tens, sec_units} == '0;
    last   = {min_tens, min_units, sec_tens} == '0 && sec_units == 4'd1;
    do_ld  = !Clear && Load && state != RUN;
    do_add = !Clear && !Load && Add30;
    do_st  = !Clear && !Load && !Add30 && Start && (state == IDLE || state == PAUSED) && !zero;
    do_ps  = !Clear && !Load && !Add30 && !Start && Pause && state == RUN;
    tick   = state == RUN && !Clear && !do_add && !do_ps && presc == LAST;
  end
  always_comb begin
    st_c = sec_tens >= 3'd3;
    a_st = st_c ? sec_tens - 3'd3 : sec_tens + 3'd3;
    mu_c = st_c && min_units == 4'd9;
    a_mu = st_c ? (min_units == 4'd9 ? 4'd0 : min_units + 4'd1) : min_units;
    a_mt = mu_c ? min_tens + 4'd1 : min_tens;
    sat  = mu_c && min_tens >= MT;
    b0   = sec_units == 4'd0;
    b1   = b0 && sec_tens == 3'd0;
    b2   = b1 && min_units == 4'd0;
    d_su = b0 ? 4'd9 : sec_units - 4'd1;
    d_st = b0 ? (sec_tens == 3'd0 ? 3'd5 : sec_tens - 3'd1) : sec_tens;
    d_mu = b1 ? (min_units == 4'd0 ? 4'd9 : min_units - 4'd1) : min_units;
    d_mt = b2 ? min_tens - 4'd1 : min_tens;
  end
  always_comb begin
    mt_n = Clear ? 4'd0 : do_ld ? (load_min_tens > MT ? MT : load_min_tens) :
           do_add ? (sat ? MT : a_mt) : tick ? d_mt : min_tens;
    mu_n = Clear ? 4'd0 : do_ld ? (load_min_units > 4'd9 ? 4'd9 : load_min_units) :
           do_add ? (sat ? 4'd9 : a_mu) : tick ? d_mu : min_units;
    st_n = Clear ? 3'd0 : do_ld ? (load_sec_tens > 3'd5 ? 3'd5 : load_sec_tens) :
           do_add ? (sat ? 3'd5 : a_st) : tick ? d_st : sec_tens;
    su_n = Clear ? 4'd0 : do_ld ? (load_sec_units > 4'd9 ? 4'd9 : load_sec_units) :
           do_add ? (sat ? 4'd9 : sec_units) : tick ? d_su : sec_units;
    presc_next = Clear || do_st ? '0 :
                 state == RUN && !do_add && !do_ps ? (presc == LAST ? '0 : presc + PW'(1)) : presc;
  end
  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = Clear ? IDLE : do_ld ? IDLE : do_add ? (state == DONE ? RUN : state) :
                 do_st ? RUN : do_ps ? PAUSED : tick && last ? DONE : state;
  end
  always_comb begin
    timer_done = state == DONE;
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      {min_tens, min_units, sec_tens, sec_units} <= '0;
      presc      <= '0;
      done_pulse <= 1'b0;
    end else begin
      {min_tens, min_units, sec_tens, sec_units} <= {mt_n, mu_n, st_n, su_n};
      presc      <= presc_next;
      done_pulse <= state_next == DONE && state != DONE;
    end
  end
endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter CLK_DIV, default 1, CLK cycles per one-second tick while running; legal range 1..2^20.
REQ-002 Parameter MAX_MIN_TENS, default 9, upper bound of the minutes-tens digit; legal range 0..9.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Load  input  1  capture load_* digits into the count.
REQ-006 load_min_tens  input  4  BCD minutes tens.
REQ-007 load_min_units  input  4  BCD minutes units.
REQ-008 load_sec_tens  input  3  seconds tens, 0..5.
REQ-009 load_sec_units  input  4  BCD seconds units.
REQ-010 Start  input  1  begin or resume the countdown.
REQ-011 Pause  input  1  suspend the countdown.
REQ-012 Clear  input  1  zero the count and return to IDLE.
REQ-013 Add30  input  1  add 30 s to the count (quick-start).
REQ-014 min_tens, min_units  output  4 each  current minutes digits.
REQ-015 sec_tens  output  3  current seconds tens.
REQ-016 sec_units  output  4  current seconds units.
REQ-017 state  output  2  IDLE=0, RUN=1, PAUSED=2, DONE=3.
REQ-018 timer_done  output  1  level; high in DONE.
REQ-019 done_pulse  output  1  one-cycle pulse on entry to DONE.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, PAUSED and DONE.
REQ-021 Command priority SHALL be Clear > Load > Add30 > Start > Pause; only the highest active command acts in a cycle.
REQ-022 Clear, in any state: count 00:00, prescaler 0, next state IDLE.
REQ-023 Load SHALL act in IDLE, PAUSED and DONE, and SHALL be ignored in RUN.
- On Load, each digit SHALL be clamped to its maximum: min_tens to MAX_MIN_TENS, other BCD digits to 9, sec_tens to 5.
- After Load the next state SHALL be IDLE.
REQ-024 Add30 in any state SHALL add 30 s with BCD carry through all digits.
- Result SHALL saturate at MAX_MIN_TENS:9:5:9.
- From DONE, Add30 SHALL set the count to 00:30 and enter RUN (quick-start).
- Other states SHALL be unchanged.
REQ-025 Start in IDLE or PAUSED with a nonzero count SHALL enter RUN.
- Prescaler SHALL be cleared on entry.
- Start with a zero count SHALL be ignored.
REQ-026 Pause in RUN SHALL enter PAUSED; the count and prescaler SHALL be held.
REQ-027 In RUN the prescaler SHALL count 0..CLK_DIV-1.
- A tick SHALL occur in the cycle it equals CLK_DIV-1, and it SHALL then wrap to 0.
- With CLK_DIV=1 every RUN cycle SHALL tick.
REQ-028 Each tick SHALL decrement the count by one second with borrow:
- sec_units 0 -> 9 and borrow sec_tens;
- sec_tens 0 -> 5 and borrow min_units;
- min_units 0 -> 9 and borrow min_tens.
REQ-029 A tick that decrements the count from 00:01 to 00:00 SHALL enter DONE in the same edge.
- done_pulse SHALL be high for exactly the following cycle.
REQ-030 In DONE the count SHALL hold at 00:00 and timer_done SHALL be 1.
- Start and Pause SHALL be ignored in DONE.
REQ-031 The count SHALL never underflow below 00:00 and never exceed the saturation value.
REQ-032 timer_done SHALL be 1 exactly when state==DONE; done_pulse SHALL never assert outside DONE entry.
REQ-033 Add30 arriving in the same cycle as a final tick SHALL win: add to the pre-tick count, remain in RUN, no done_pulse.

Reset
REQ-034 On Reset: count 00:00, state IDLE, prescaler 0, timer_done 0, done_pulse 0.
REQ-035 Reset SHALL override every command and SHALL abort RUN, PAUSED or DONE mid-operation within one edge.

Verification
REQ-036 CLK_DIV=4: Load 00:03, Start -> sec_units 2,1,0 at 4-cycle spacing; DONE, with a single done_pulse, 12 cycles after Start.
REQ-037 Load 01:00, Start, one tick -> 00:59; Load 10:00, one tick -> 09:59 (full borrow chain).
REQ-038 RUN at 00:45 with CLK_DIV=4, Pause after 2 cycles, wait 10 cycles, Start -> next tick arrives 4 cycles after Start (prescaler cleared by Start), count 00:44.
REQ-039 Add30: at 09:45 -> 10:15; at 99:50 -> 99:59 saturated; in DONE -> 00:30 and state RUN.
REQ-040 Load digits 0xF,0xC,7,0xA -> count 99:59 (clamped); Start with count 00:00 -> stays IDLE.
REQ-041 Reset asserted in RUN at 05:17 together with Load and Start -> count 00:00, state IDLE, timer_done 0 next cycle.
